// File: rtl/alu_issue_queue_pkg.sv
// rtl/alu_issue_queue_pkg.sv - opcode constants, legal-opcode test and command struct
package alu_pkg;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b01110;
  localparam logic [4:0] OP_SLT  = 5'b01111;
  localparam logic [4:0] OP_NOR  = 5'b11000;
  localparam logic [4:0] OP_NAND = 5'b11001;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  function automatic logic op_legal(input logic [4:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// rtl/alu_issue_queue_if.sv - command, ALU and result signal bundle of the issue queue
interface alu_issue_queue_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_op;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [4:0]       alu_op;
  logic [31:0]      alu_s;
  logic             alu_eq;
  logic             alu_ovf;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_s;
  logic             res_eq;
  logic             res_ovf;
  logic             res_err;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_s, alu_eq, alu_ovf, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, res_valid, res_s, res_eq, res_ovf, res_err, ovf_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_s, alu_eq, alu_ovf, res_ready,
    output cmd_ready, alu_a, alu_b, alu_op, res_valid, res_s, res_eq, res_ovf, res_err, ovf_count
  );
endinterface

// File: rtl/alu_issue_queue_cmd_fifo.sv
// rtl/alu_issue_queue_cmd_fifo.sv - DEPTH-entry synchronous command FIFO with registered full/empty
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags are computed from the next count so they stay registered yet exact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - command FIFO, issue register and result capture in front of the ALU
// Optional ALU_OPCODE_CHECK_EN: illegal opcodes are kept off the ALU and returned with res_err=1.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_queue_if.slave bus
);
  cmd_t             push_cmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue_adv;
  logic             pop;
  logic             head_ok;
  logic             slot_err;
  logic             iss_valid;
  logic [31:0]      alu_a_q;
  logic [31:0]      alu_b_q;
  logic [4:0]       alu_op_q;
  logic             res_valid_q;
  logic [31:0]      res_s_q;
  logic             res_eq_q;
  logic             res_ovf_q;
  logic             res_err_q;
  logic [CNT_W-1:0] ovf_cnt;

  assign push_cmd  = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  assign issue_adv = ~res_valid_q | bus.res_ready;
  assign pop       = issue_adv & ~fifo_empty;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ALU_OPCODE_CHECK_EN
  logic iss_err;

  assign head_ok  = op_legal(head.op);
  assign slot_err = iss_err;

  always_ff @(posedge clk) begin
    if (!rst_n)   iss_err <= 1'b0;
    else if (pop) iss_err <= ~head_ok;
  end
`else
  assign head_ok  = 1'b1;
  assign slot_err = 1'b0;
`endif

  // An illegal slot leaves alu_* untouched so the ALU never sees its operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
    end else if (issue_adv) begin
      iss_valid <= ~fifo_empty;
      if (pop && head_ok) begin
        alu_a_q  <= head.a;
        alu_b_q  <= head.b;
        alu_op_q <= head.op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_eq_q    <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else if (issue_adv && iss_valid) begin
      res_valid_q <= 1'b1;
      res_s_q     <= slot_err ? '0   : bus.alu_s;
      res_eq_q    <= slot_err ? 1'b0 : bus.alu_eq;
      res_ovf_q   <= slot_err ? 1'b0 : bus.alu_ovf;
      res_err_q   <= slot_err;
    end else if (bus.res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (res_valid_q && bus.res_ready && res_ovf_q && !(&ovf_cnt)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign bus.cmd_ready = ~fifo_full;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_s     = res_s_q;
  assign bus.res_eq    = res_eq_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_err   = res_err_q;
  assign bus.ovf_count = ovf_cnt;

endmodule
